// File: rtl/wash_view_ctrl.sv
// Washer front-panel view controller: phase/power/set/colour LEDs, blink tick, digit scan, finish flash.
// Optional WASH_VIEW_PAUSE_DIM_EN: dims phase LEDs with a 25% PWM while paused.
module wash_view_ctrl #(
   parameter int unsigned            NUM_PHASES  = 8,
   parameter int unsigned            NUM_DIGITS  = 6,
   parameter int unsigned            BLINK_DIV   = 25000000,
   parameter int unsigned            SCAN_DIV    = 50000,
   parameter int unsigned            FLASH_COUNT = 3,
   parameter logic [NUM_DIGITS-1:0]  PAUSE_MASK  = NUM_DIGITS'(6'b001100),
   localparam int unsigned           AP_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic                      cp,
   input  logic                      rst,
   input  logic [2:0]                state,
   input  logic [NUM_PHASES-1:0]     phase_mask,
   input  logic [AP_W-1:0]           active_phase,
   input  logic                      power_on,
   input  logic                      set_on,
   input  logic [6*NUM_DIGITS-1:0]   digit_code,
   output logic [NUM_PHASES-1:0]     phase_led,
   output logic                      power_led,
   output logic                      set_led,
   output logic [2:0]                color_led,
   output logic                      blink,
   output logic [5:0]                seg_code,
   output logic [NUM_DIGITS-1:0]     digit_sel
);

   localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned SEL_W   = $clog2(6 * NUM_DIGITS);
   localparam int unsigned FCNT_W  = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT + 1) : 1;

   localparam logic [5:0] GLYPH_EMPTY = 6'd55;
   localparam logic [5:0] GLYPH_FULL  = 6'd56;
   localparam logic [5:0] GLYPH_PAUSE = 6'd57;

   typedef enum logic [2:0] {
      ST_SHUT   = 3'd0,
      ST_BEGIN  = 3'd1,
      ST_SET    = 3'd2,
      ST_RUN    = 3'd3,
      ST_ERROR  = 3'd4,
      ST_PAUSE  = 3'd5,
      ST_FINISH = 3'd6
   } panel_state_t;

   typedef enum logic [1:0] {FL_IDLE, FL_FLASH, FL_HOLD} flash_state_t;

   logic [BLINK_W-1:0]    r_blink_cnt;
   logic                  r_blink;
   logic [SCAN_W-1:0]     r_scan_cnt;
   logic [IDX_W-1:0]      r_idx;
   panel_state_t          r_prev_st;
   flash_state_t          r_flash;
   logic [FCNT_W-1:0]     r_flash_cnt;
   logic [2:0]            r_color;
   logic [NUM_PHASES-1:0] r_phase;
   logic                  r_power;
   logic                  r_set;
   logic [5:0]            r_seg;
   logic [NUM_DIGITS-1:0] r_digit_sel;

   panel_state_t          w_st;
   logic                  w_blink_wrap, w_blink_nxt, w_tick, w_scan_wrap;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic [SEL_W-1:0]      w_code_base;
   flash_state_t          w_flash_nxt;
   logic [FCNT_W-1:0]     w_flash_cnt_nxt;
   logic [NUM_PHASES-1:0] w_phase_nxt;
   logic [5:0]            w_seg_nxt;
   logic [2:0]            w_color_nxt;
   logic                  w_set_nxt;

   // Illegal encoding 7 behaves as shutDown
   assign w_st         = (state == 3'd7) ? ST_SHUT : panel_state_t'(state);
   assign w_blink_wrap = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));
   assign w_blink_nxt  = w_blink_wrap ? ~r_blink : r_blink;
   assign w_tick       = w_blink_wrap & ~r_blink;
   assign w_scan_wrap  = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign w_idx_nxt    = !w_scan_wrap ? r_idx :
                         (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
   assign w_code_base  = SEL_W'(w_idx_nxt) * SEL_W'(6);

`ifdef WASH_VIEW_PAUSE_DIM_EN
   logic [1:0] r_pwm_cnt;
   always_ff @(posedge cp) begin
      if (rst) r_pwm_cnt <= 2'd0;
      else     r_pwm_cnt <= r_pwm_cnt + 2'd1;
   end
`endif

   // Flash FSM next state: entry edge into finish restarts the sequence
   always_comb begin
      w_flash_nxt     = r_flash;
      w_flash_cnt_nxt = r_flash_cnt;
      if (w_st != ST_FINISH) begin
         w_flash_nxt = FL_IDLE;
      end else if (r_prev_st != ST_FINISH) begin
         w_flash_nxt     = FL_FLASH;
         w_flash_cnt_nxt = '0;
      end else if (r_flash == FL_FLASH && w_tick) begin
         if (r_flash_cnt == FCNT_W'(FLASH_COUNT - 1)) w_flash_nxt = FL_HOLD;
         else w_flash_cnt_nxt = r_flash_cnt + FCNT_W'(1);
      end
   end

   always_ff @(posedge cp) begin
      if (rst) begin
         r_flash     <= FL_IDLE;
         r_flash_cnt <= '0;
      end else begin
         r_flash     <= w_flash_nxt;
         r_flash_cnt <= w_flash_cnt_nxt;
      end
   end

   always_comb begin
      w_phase_nxt = phase_mask;
      w_seg_nxt   = digit_code[w_code_base +: 6];
      w_color_nxt = 3'd0;
      w_set_nxt   = set_on;
      case (w_st)
         ST_SHUT: begin
            w_phase_nxt = '0;
            w_seg_nxt   = GLYPH_EMPTY;
            w_set_nxt   = 1'b0;
         end
         ST_BEGIN: begin
            w_phase_nxt = '1;
            w_seg_nxt   = GLYPH_FULL;
            w_set_nxt   = 1'b1;
         end
         ST_RUN: begin
            if (32'(active_phase) < NUM_PHASES) w_phase_nxt[active_phase] = w_blink_nxt;
            w_color_nxt = w_tick ? r_color + 3'd1 : r_color;
         end
         ST_PAUSE: begin
`ifdef WASH_VIEW_PAUSE_DIM_EN
            w_phase_nxt = phase_mask & {NUM_PHASES{r_pwm_cnt == 2'd0}};
`else
            w_phase_nxt = phase_mask;
`endif
            if (PAUSE_MASK[w_idx_nxt]) w_seg_nxt = GLYPH_PAUSE;
         end
         ST_FINISH: begin
            w_phase_nxt = (w_flash_nxt == FL_FLASH) ? {NUM_PHASES{w_blink_nxt}} : '1;
            w_seg_nxt   = GLYPH_FULL;
            w_set_nxt   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge cp) begin
      if (rst) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b0;
         r_scan_cnt  <= '0;
         r_idx       <= '0;
         r_prev_st   <= ST_SHUT;
         r_color     <= 3'd0;
         r_phase     <= '0;
         r_power     <= 1'b0;
         r_set       <= 1'b0;
         r_seg       <= GLYPH_EMPTY;
         r_digit_sel <= NUM_DIGITS'(1);
      end else begin
         r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BLINK_W'(1);
         r_blink     <= w_blink_nxt;
         r_scan_cnt  <= w_scan_wrap ? '0 : r_scan_cnt + SCAN_W'(1);
         r_idx       <= w_idx_nxt;
         r_prev_st   <= w_st;
         r_color     <= w_color_nxt;
         r_phase     <= w_phase_nxt;
         r_power     <= power_on;
         r_set       <= w_set_nxt;
         r_seg       <= w_seg_nxt;
         r_digit_sel <= NUM_DIGITS'(1) << w_idx_nxt;
      end
   end

   assign phase_led = r_phase;
   assign power_led = r_power;
   assign set_led   = r_set;
   assign color_led = r_color;
   assign blink     = r_blink;
   assign seg_code  = r_seg;
   assign digit_sel = r_digit_sel;

endmodule

// File: tb/tb_wash_view_ctrl.sv
// Bench for wash_view_ctrl: small parameters, reference model derived from the cycle count since reset.
module tb_wash_view_ctrl;

   localparam int unsigned NP = 8;
   localparam int unsigned ND = 3;
   localparam int unsigned BD = 4;
   localparam int unsigned SD = 2;
   localparam int unsigned FC = 3;
   localparam logic [ND-1:0] PM = 3'b010;

   logic          cp = 1'b0;
   logic          rst;
   logic [2:0]    state;
   logic [NP-1:0] phase_mask;
   logic [2:0]    active_phase;
   logic          power_on, set_on;
   logic [6*ND-1:0] digit_code;
   logic [NP-1:0] phase_led;
   logic          power_led, set_led, blink;
   logic [2:0]    color_led;
   logic [5:0]    seg_code;
   logic [ND-1:0] digit_sel;

   int total = 0;
   int bad   = 0;

   wash_view_ctrl #(
      .NUM_PHASES(NP), .NUM_DIGITS(ND), .BLINK_DIV(BD), .SCAN_DIV(SD),
      .FLASH_COUNT(FC), .PAUSE_MASK(PM)
   ) dut (
      .cp(cp), .rst(rst), .state(state), .phase_mask(phase_mask),
      .active_phase(active_phase), .power_on(power_on), .set_on(set_on),
      .digit_code(digit_code), .phase_led(phase_led), .power_led(power_led),
      .set_led(set_led), .color_led(color_led), .blink(blink),
      .seg_code(seg_code), .digit_sel(digit_sel)
   );

   always #5 cp = ~cp;

   // Reference model: blink and scan position follow from the edge count n since reset
   int unsigned n = 0;
   int unsigned m_fl_ticks = 0;
   int unsigned m_prev = 0;
   logic [NP-1:0] e_phase;
   logic          e_power, e_set, e_blink;
   logic [2:0]    e_color;
   logic [5:0]    e_seg;
   logic [ND-1:0] e_dsel;

   always @(posedge cp) begin : ref_model
      int unsigned s, idx;
      logic bl, tk;
      logic [5:0] code;
      if (rst) begin
         n = 0; m_prev = 0; m_fl_ticks = 0;
         e_phase = '0; e_power = 1'b0; e_set = 1'b0; e_blink = 1'b0;
         e_color = 3'd0; e_seg = 6'd55; e_dsel = 3'b001;
      end else begin
         n    = n + 1;
         s    = (state == 3'd7) ? 0 : int'(state);
         bl   = ((n / BD) % 2) == 1;
         tk   = ((n % BD) == 0) && bl;
         idx  = (n / SD) % ND;
         code = digit_code[idx*6 +: 6];
         if (s == 6) begin
            if (m_prev != 6) m_fl_ticks = 0;
            else if (tk) m_fl_ticks = m_fl_ticks + 1;
         end
         if (s == 3) begin
            if (tk) e_color = e_color + 3'd1;
         end else begin
            e_color = 3'd0;
         end
         case (s)
            0: e_phase = '0;
            1: e_phase = '1;
            3: begin e_phase = phase_mask; e_phase[active_phase] = bl; end
            5: begin
`ifdef WASH_VIEW_PAUSE_DIM_EN
               e_phase = (((n - 1) % 4) == 0) ? phase_mask : '0;
`else
               e_phase = phase_mask;
`endif
            end
            6: e_phase = (m_fl_ticks >= FC) ? '1 : {NP{bl}};
            default: e_phase = phase_mask;
         endcase
         case (s)
            0:       e_seg = 6'd55;
            1, 6:    e_seg = 6'd56;
            5:       e_seg = PM[idx] ? 6'd57 : code;
            default: e_seg = code;
         endcase
         e_set   = (s == 1 || s == 6) ? 1'b1 : (s == 0) ? 1'b0 : set_on;
         e_power = power_on;
         e_blink = bl;
         e_dsel  = ND'(1 << idx);
         m_prev  = s;
      end
   end

   task automatic test_reset();
      rst = 1'b1; state = 3'd0; phase_mask = 8'($urandom); active_phase = 3'($urandom);
      power_on = 1'b1; set_on = 1'b1; digit_code = 18'($urandom);
      repeat (3) @(negedge cp);
      total++; if (phase_led !== 8'h00) begin bad++; $display("FAIL rst_phase_led: got %h want 00", phase_led); end
      total++; if (power_led !== 1'b0) begin bad++; $display("FAIL rst_power_led: got %b want 0", power_led); end
      total++; if (set_led !== 1'b0) begin bad++; $display("FAIL rst_set_led: got %b want 0", set_led); end
      total++; if (color_led !== 3'd0) begin bad++; $display("FAIL rst_color_led: got %0d want 0", color_led); end
      total++; if (blink !== 1'b0) begin bad++; $display("FAIL rst_blink: got %b want 0", blink); end
      total++; if (seg_code !== 6'd55) begin bad++; $display("FAIL rst_seg_code: got %0d want 55", seg_code); end
      total++; if (digit_sel !== 3'b001) begin bad++; $display("FAIL rst_digit_sel: got %b want 001", digit_sel); end
      rst = 1'b0; power_on = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge cp);
         total++; if (digit_sel !== e_dsel) begin bad++; $display("FAIL shut_digit_sel: got %b want %b", digit_sel, e_dsel); end
         total++; if (seg_code !== 6'd55) begin bad++; $display("FAIL shut_seg_code: got %0d want 55", seg_code); end
         total++; if ({phase_led, power_led, set_led, color_led} !== '0) begin
            bad++; $display("FAIL shut_leds: got %h/%b/%b/%0d want all 0", phase_led, power_led, set_led, color_led);
         end
      end
   endtask

   task automatic test_run_blink();
      state = 3'd3; phase_mask = 8'hF0; active_phase = 3'd5; set_on = 1'($urandom);
      for (int i = 0; i < 24; i++) begin
         @(negedge cp);
         total++; if (phase_led !== e_phase) begin bad++; $display("FAIL run_phase_led: got %h want %h", phase_led, e_phase); end
         total++; if (phase_led !== 8'hD0 && phase_led !== 8'hF0) begin bad++; $display("FAIL run_phase_pattern: got %h want D0 or F0", phase_led); end
         total++; if (color_led !== e_color) begin bad++; $display("FAIL run_color_led: got %0d want %0d", color_led, e_color); end
         total++; if (blink !== e_blink) begin bad++; $display("FAIL run_blink: got %b want %b", blink, e_blink); end
         total++; if (set_led !== e_set) begin bad++; $display("FAIL run_set_led: got %b want %b", set_led, e_set); end
      end
      state = 3'd5;
      @(negedge cp);
      total++; if (color_led !== 3'd0) begin bad++; $display("FAIL pause_color_clear: got %0d want 0", color_led); end
   endtask

   task automatic test_finish_flash();
      state = 3'd3;
      repeat (4) @(negedge cp);
      state = 3'd6;
      for (int i = 0; i < 40; i++) begin
         @(negedge cp);
         total++; if (phase_led !== e_phase) begin bad++; $display("FAIL flash_phase_led: got %h want %h", phase_led, e_phase); end
         total++; if (set_led !== 1'b1) begin bad++; $display("FAIL flash_set_led: got %b want 1", set_led); end
         total++; if (seg_code !== 6'd56) begin bad++; $display("FAIL flash_seg_code: got %0d want 56", seg_code); end
      end
      total++; if (phase_led !== 8'hFF) begin bad++; $display("FAIL flash_hold: got %h want FF", phase_led); end
   endtask

   task automatic test_reenter();
      state = 3'd3;
      repeat (2) @(negedge cp);
      state = 3'd6;
      for (int i = 0; i < 10; i++) begin
         @(negedge cp);
         total++; if (phase_led !== e_phase) begin bad++; $display("FAIL reenter_first_phase: got %h want %h", phase_led, e_phase); end
      end
      state = 3'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge cp);
         total++; if (phase_led !== e_phase) begin bad++; $display("FAIL reenter_run_phase: got %h want %h", phase_led, e_phase); end
      end
      state = 3'd6;
      for (int i = 0; i < 36; i++) begin
         @(negedge cp);
         total++; if (phase_led !== e_phase) begin bad++; $display("FAIL reenter_flash_phase: got %h want %h", phase_led, e_phase); end
      end
   endtask

   task automatic test_pause_scan();
      state = 3'd5; digit_code = {6'd3, 6'd2, 6'd1}; phase_mask = 8'($urandom);
      for (int i = 0; i < 12; i++) begin
         @(negedge cp);
         total++; if (seg_code !== e_seg) begin bad++; $display("FAIL pause_seg_code: got %0d want %0d", seg_code, e_seg); end
         total++; if (digit_sel !== e_dsel) begin bad++; $display("FAIL pause_digit_sel: got %b want %b", digit_sel, e_dsel); end
         total++; if (phase_led !== e_phase) begin bad++; $display("FAIL pause_phase_led: got %h want %h", phase_led, e_phase); end
      end
   endtask

   task automatic test_pause_dim();
      int unsigned lit = 0;
      state = 3'd5; phase_mask = 8'hFF;
      for (int i = 0; i < 16; i++) begin
         @(negedge cp);
         total++; if (phase_led !== e_phase) begin bad++; $display("FAIL dim_phase_led: got %h want %h", phase_led, e_phase); end
         if (phase_led === 8'hFF) lit++;
      end
`ifdef WASH_VIEW_PAUSE_DIM_EN
      total++; if (lit != 4) begin bad++; $display("FAIL dim_duty: got %0d lit cycles want 4", lit); end
`else
      total++; if (lit != 16) begin bad++; $display("FAIL dim_duty: got %0d lit cycles want 16", lit); end
`endif
   endtask

   task automatic test_random();
      for (int seg = 0; seg < 80; seg++) begin
         rst          = ($urandom_range(0, 99) < 4);
         state        = 3'($urandom_range(0, 7));
         phase_mask   = 8'($urandom);
         active_phase = 3'($urandom);
         power_on     = 1'($urandom);
         set_on       = 1'($urandom);
         digit_code   = 18'($urandom);
         for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
            @(negedge cp);
            total++; if (phase_led !== e_phase) begin bad++; $display("FAIL rnd_phase_led: got %h want %h", phase_led, e_phase); end
            total++; if (power_led !== e_power) begin bad++; $display("FAIL rnd_power_led: got %b want %b", power_led, e_power); end
            total++; if (set_led !== e_set) begin bad++; $display("FAIL rnd_set_led: got %b want %b", set_led, e_set); end
            total++; if (color_led !== e_color) begin bad++; $display("FAIL rnd_color_led: got %0d want %0d", color_led, e_color); end
            total++; if (blink !== e_blink) begin bad++; $display("FAIL rnd_blink: got %b want %b", blink, e_blink); end
            total++; if (seg_code !== e_seg) begin bad++; $display("FAIL rnd_seg_code: got %0d want %0d", seg_code, e_seg); end
            total++; if (digit_sel !== e_dsel) begin bad++; $display("FAIL rnd_digit_sel: got %b want %b", digit_sel, e_dsel); end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_run_blink();
      test_finish_flash();
      test_reenter();
      test_pause_scan();
      test_pause_dim();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wash_view_ctrl.md
Name: wash_view_ctrl

Overview:
Parametrised front-panel view controller for the washer. It drives the phase LEDs, power/set/colour LEDs and a multiplexed digit scan from the controller state, phase mask and digit codes. It generates its own blink tick and adds an end-of-cycle flash sequence and a scanned digit output. Its outputs feed the existing segment decoder and board LEDs.

Parameters:
NUM_PHASES, 8, number of phase LEDs (index 0 = first phase).
NUM_DIGITS, 6, number of scanned digits.
BLINK_DIV, 25000000, cp cycles per blink half-period.
SCAN_DIV, 50000, cp cycles per digit scan slot.
FLASH_COUNT, 3, full blink periods flashed on entering finish.
PAUSE_MASK, 6'b001100, digits that show the pause glyph in pause state (NUM_DIGITS bits).

Ports:
cp  in  1  clock.
rst  in  1  reset; synchronous, active-high.
state  in  3  0 shutDown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish.
phase_mask  in  NUM_PHASES  selected/remaining phases.
active_phase  in  clog2(NUM_PHASES)  phase currently running.
power_on  in  1  power indicator source.
set_on  in  1  set indicator source.
digit_code  in  6*NUM_DIGITS  per-digit 6-bit glyph codes; digit i is [6i+5:6i].
phase_led  out  NUM_PHASES  phase LEDs.
power_led  out  1  power LED.
set_led  out  1  set LED.
color_led  out  3  run-progress colour LED.
blink  out  1  internal blink square wave.
seg_code  out  6  glyph code of the scanned digit.
digit_sel  out  NUM_DIGITS  one-hot digit enable.

Behaviour:
- All outputs are registered. Each output responds 1 cycle after its input changes.
- Reset values: phase_led 0, power_led 0, set_led 0, color_led 0, blink 0, digit_sel 1 (one-hot, bit 0 set), seg_code 55. All counters are 0 and the flash FSM is IDLE.
- Blink: a counter runs 0..BLINK_DIV-1. blink toggles on the wrap cycle. A blink rising edge is the tick used below.
- color_led: in run, +1 per tick, wrapping 7->0. In any other state it is cleared to 0 on the next cycle.
- Glyph codes: 55 = empty, 56 = full, 57 = pause.
- Digit code per digit:
  - shutDown: 55.
  - begin and finish: 56.
  - pause: 57 where PAUSE_MASK bit is set, otherwise digit_code.
  - other states: digit_code.
- Scan: a counter runs 0..SCAN_DIV-1. On wrap, the index advances and wraps from NUM_DIGITS-1 to 0. digit_sel and seg_code update in the same cycle and always refer to the same index.
- Phase LEDs:
  - shutDown: 0.
  - begin: all 1.
  - run: phase_mask with bit active_phase replaced by blink. If active_phase >= NUM_PHASES, plain phase_mask.
  - finish: driven by the flash FSM.
  - others: phase_mask.
- Flash FSM, states IDLE/FLASH/HOLD:
  - IDLE->FLASH on the first cycle state==6 while the previous state was not 6. The tick count is cleared at this point.
  - In FLASH, all phase LEDs = blink.
  - FLASH->HOLD after FLASH_COUNT ticks. In HOLD, all phase LEDs = 1.
  - Leaving finish from FLASH or HOLD returns to IDLE in the same cycle.
  - Re-entering finish restarts the flash sequence.
- power_led = power_on.
- set_led: 1 in begin/finish, 0 in shutDown, otherwise set_on.
- Reset mid-scan or mid-flash returns every output and counter to its reset value on the next edge.
- Illegal state 7: treated as shutDown.

Optional Feature:
Macro WASH_VIEW_PAUSE_DIM_EN.
- Defined: in pause, phase_led = phase_mask AND a 25% PWM. The PWM is high when a free-running 2-bit cp counter equals 0.
- Undefined: pause shows phase_mask steadily, and no PWM counter is built.

Test Plan:
1. Reset, state 0 -> all LEDs 0, digit_sel scans 001,010,100 (NUM_DIGITS=3, SCAN_DIV=2), seg_code 55 every slot.
2. BLINK_DIV=4, state 3, phase_mask 8'b1111_0000, active_phase 5 -> phase_led toggles between 8'hD0 and 8'hF0 every 4 cycles; color_led 0->1->2 on successive ticks; state 5 -> color_led 0 next cycle.
3. state 3->6, FLASH_COUNT=3, BLINK_DIV=4 -> phase_led follows blink for 3 ticks, then holds 8'hFF; set_led 1; all seg_code 56.
4. state 6->3 mid-flash, then back to 6 -> FSM returns to IDLE, then restarts with a full 3-tick flash.
5. state 5, PAUSE_MASK 3'b010, digit_code {6'd3,6'd2,6'd1} -> seg_code sequence 1,57,3.
6. With WASH_VIEW_PAUSE_DIM_EN defined, state 5, phase_mask 8'hFF -> phase_led 8'hFF for 1 of every 4 cycles, otherwise 0. With the macro undefined, steady 8'hFF.
